// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
// Forwarding muxes, single-cycle ALU, branch decision/target, and an
// iterative radix-2 multiply/divide unit that stalls the pipeline.
// Optional feature macro: EX_PERF_CNT_EN adds a saturating 32-bit stall counter.
//
// Handshake: ex_stall_out=1 means the instruction in EX is not finished.
// PC, IF/ID and ID/EX hold, and a bubble enters EX/MEM. When the stall drops
// with a mul/div in DONE, result_out is valid until advance (or flush) is seen.
module ex_stage #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  advance,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] readdata1_in,
    input  logic [DATA_WIDTH-1:0] readdata2_in,
    input  logic [DATA_WIDTH-1:0] imm_data_in,
    input  logic [3:0]            funct4_in,
    input  logic [1:0]            aluop_in,
    input  logic                  alusrc_in,
    input  logic                  branch_in,
    input  logic                  muldiv_in,
    input  logic [1:0]            fwd_a_sel,
    input  logic [1:0]            fwd_b_sel,
    input  logic [DATA_WIDTH-1:0] exmem_result_in,
    input  logic [DATA_WIDTH-1:0] wb_data_in,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic [DATA_WIDTH-1:0] store_data_out,
    output logic                  branch_taken_out,
    output logic [DATA_WIDTH-1:0] branch_target_out,
    output logic                  ex_stall_out
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles_out
`endif
);

    localparam int DW      = DATA_WIDTH;
    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int CNT_W   = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    md_state_t            state, state_next;
    logic [DW-1:0]        rs1_fwd, rs2_fwd, op_a, op_b, alu_res;
    logic [2:0]           funct3;
    logic [SHAMT_W-1:0]   shamt;
    logic                 lt_s, lt_u, br_cond;
    logic                 md_start, md_done, md_signed;
    logic [CNT_W-1:0]     count;
    logic [DW-1:0]        acc_hi, acc_lo, opnd_b;
    logic [2:0]           md_op;
    logic [1:0]           sign_flags;
    logic [DW:0]          mul_sum, div_shifted;
    logic [DW-1:0]        div_diff, md_res;
    logic                 div_ge;

    assign funct3 = funct4_in[2:0];

    // Operand forwarding; select code 11 behaves like 00
    always_comb begin
        rs1_fwd = readdata1_in;
        rs2_fwd = readdata2_in;
        case (fwd_a_sel)
            2'b01:   rs1_fwd = wb_data_in;
            2'b10:   rs1_fwd = exmem_result_in;
            default: rs1_fwd = readdata1_in;
        endcase
        case (fwd_b_sel)
            2'b01:   rs2_fwd = wb_data_in;
            2'b10:   rs2_fwd = exmem_result_in;
            default: rs2_fwd = readdata2_in;
        endcase
    end

    assign op_a           = rs1_fwd;
    assign op_b           = alusrc_in ? imm_data_in : rs2_fwd;
    assign shamt          = op_b[SHAMT_W-1:0];
    assign store_data_out = rs2_fwd;

    // Single-cycle ALU; funct4[3] only selects SUB for register operands
    always_comb begin
        alu_res = '0;
        case (aluop_in)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_res = (funct4_in[3] && !alusrc_in) ? op_a - op_b : op_a + op_b;
                    3'b001:  alu_res = op_a << shamt;
                    3'b010:  alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                    3'b011:  alu_res = {{(DW-1){1'b0}}, (op_a < op_b)};
                    3'b100:  alu_res = op_a ^ op_b;
                    3'b101:  alu_res = funct4_in[3] ? DW'($signed(op_a) >>> shamt) : op_a >> shamt;
                    3'b110:  alu_res = op_a | op_b;
                    default: alu_res = op_a & op_b;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // Branch condition always compares forwarded rs1 against forwarded rs2
    always_comb begin
        lt_s    = $signed(rs1_fwd) < $signed(rs2_fwd);
        lt_u    = rs1_fwd < rs2_fwd;
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rs1_fwd == rs2_fwd);
            3'b001:  br_cond = (rs1_fwd != rs2_fwd);
            3'b100:  br_cond = lt_s;
            3'b101:  br_cond = !lt_s;
            3'b110:  br_cond = lt_u;
            3'b111:  br_cond = !lt_u;
            default: br_cond = 1'b0;
        endcase
    end

    assign branch_taken_out  = branch_in && br_cond && !flush && !reset;
    assign branch_target_out = pc_in + imm_data_in;

    // Mul/div FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_next;
    end

    // Mul/div FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (muldiv_in && !flush) state_next = MD_BUSY;
            MD_BUSY: begin
                if (flush)                     state_next = MD_IDLE;
                else if (count == CNT_W'(1))   state_next = MD_DONE;
            end
            MD_DONE: if (advance || flush) state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Mul/div FSM outputs: start pulse, stall and result select
    always_comb begin
        md_start     = (state == MD_IDLE) && muldiv_in && !flush;
        md_done      = (state == MD_DONE);
        ex_stall_out = !reset && (md_start || (state == MD_BUSY));
    end

    // DIV and REM work on magnitudes; the sign is restored at the end
    assign md_signed = funct3[2] && !funct3[0];

    // One radix-2 step: shift-add multiply or restoring divide
    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : {(DW+1){1'b0}});
        div_shifted = {acc_hi, acc_lo[DW-1]};
        div_ge      = div_shifted >= {1'b0, opnd_b};
        div_diff    = div_shifted[DW-1:0] - opnd_b;
    end

    // Mul/div datapath registers: latch on start, step while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opnd_b     <= '0;
            md_op      <= '0;
            sign_flags <= '0;
        end else if (md_start) begin
            count      <= CNT_W'(DW);
            acc_hi     <= '0;
            acc_lo     <= (md_signed && rs1_fwd[DW-1]) ? -rs1_fwd : rs1_fwd;
            opnd_b     <= (md_signed && rs2_fwd[DW-1]) ? -rs2_fwd : rs2_fwd;
            md_op      <= funct3;
            sign_flags <= md_signed ? {rs1_fwd[DW-1], rs2_fwd[DW-1]} : 2'b00;
        end else if (state == MD_BUSY && !flush) begin
            count <= count - CNT_W'(1);
            if (!md_op[2]) begin
                acc_hi <= mul_sum[DW:1];
                acc_lo <= {mul_sum[0], acc_lo[DW-1:1]};
            end else begin
                acc_hi <= div_ge ? div_diff : div_shifted[DW-1:0];
                acc_lo <= {acc_lo[DW-2:0], div_ge};
            end
        end
    end

    // Final mul/div result with sign fix-up and divide-by-zero quotient
    always_comb begin
        md_res = '0;
        case (md_op)
            3'b000:        md_res = acc_lo;
            3'b011:        md_res = acc_hi;
            3'b100, 3'b101: begin
                if (opnd_b == '0)                     md_res = '1;
                else if (sign_flags[1] ^ sign_flags[0]) md_res = -acc_lo;
                else                                  md_res = acc_lo;
            end
            3'b110, 3'b111: md_res = sign_flags[1] ? -acc_hi : acc_hi;
            default:       md_res = '0;
        endcase
    end

    assign result_out = md_done ? md_res : alu_res;

`ifdef EX_PERF_CNT_EN
    // Saturating count of stalled cycles; only reset clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                         stall_cycles_out <= '0;
        else if (ex_stall_out && stall_cycles_out != '1)   stall_cycles_out <= stall_cycles_out + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage (DATA_WIDTH=64).
// Inputs change 1ns after the rising edge; outputs are sampled 4ns after it.
module tb_ex_stage;

    logic        clk, reset, flush, advance;
    logic [63:0] pc_in, readdata1_in, readdata2_in, imm_data_in;
    logic [3:0]  funct4_in;
    logic [1:0]  aluop_in;
    logic        alusrc_in, branch_in, muldiv_in;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [63:0] exmem_result_in, wb_data_in;
    logic [63:0] result_out, store_data_out, branch_target_out;
    logic        branch_taken_out, ex_stall_out;
`ifdef EX_PERF_CNT_EN
    logic [31:0] stall_cycles_out;
`endif

    logic [63:0] exp_q[$];
    int          checks;
    int          errors;

    ex_stage #(.DATA_WIDTH(64)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .advance           (advance),
        .pc_in             (pc_in),
        .readdata1_in      (readdata1_in),
        .readdata2_in      (readdata2_in),
        .imm_data_in       (imm_data_in),
        .funct4_in         (funct4_in),
        .aluop_in          (aluop_in),
        .alusrc_in         (alusrc_in),
        .branch_in         (branch_in),
        .muldiv_in         (muldiv_in),
        .fwd_a_sel         (fwd_a_sel),
        .fwd_b_sel         (fwd_b_sel),
        .exmem_result_in   (exmem_result_in),
        .wb_data_in        (wb_data_in),
        .result_out        (result_out),
        .store_data_out    (store_data_out),
        .branch_taken_out  (branch_taken_out),
        .branch_target_out (branch_target_out),
        .ex_stall_out      (ex_stall_out)
`ifdef EX_PERF_CNT_EN
        ,
        .stall_cycles_out  (stall_cycles_out)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h, nothing expected in queue", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic clear_inputs();
        flush = 0; advance = 0; pc_in = 0; readdata1_in = 0; readdata2_in = 0;
        imm_data_in = 0; funct4_in = 0; aluop_in = 0; alusrc_in = 0;
        branch_in = 0; muldiv_in = 0; fwd_a_sel = 0; fwd_b_sel = 0;
        exmem_result_in = 0; wb_data_in = 0;
    endtask

    // One combinational ALU operation, register operands unless src=1
    task automatic alu_op(input string tag, input logic [1:0] op, input logic [3:0] f4,
                          input logic src, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp);
        @(posedge clk); #1;
        clear_inputs();
        aluop_in = op; funct4_in = f4; alusrc_in = src;
        readdata1_in = a; readdata2_in = b; imm_data_in = b;
        push(exp);
        #3;
        chk(tag, result_out);
    endtask

    // Full mul/div transaction: start, count stall cycles, hold, advance
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int hold);
        int n;
        @(posedge clk); #1;
        clear_inputs();
        muldiv_in = 1; aluop_in = 2'b10; funct4_in = {1'b0, f3};
        readdata1_in = a; readdata2_in = b;
        push(64'd1);
        #3;
        chk({tag, " stall_start"}, 64'(ex_stall_out));
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                readdata1_in = ~a;
                readdata2_in = b ^ 64'h5;
            end
            #3;
            if (!ex_stall_out) break;
            n++;
        end
        push(64'd65);
        chk({tag, " stall_cycles"}, 64'(n));
        push(exp);
        chk({tag, " result"}, result_out);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #4;
            push(exp);
            chk({tag, " hold_result"}, result_out);
            push(64'd0);
            chk({tag, " hold_stall"}, 64'(ex_stall_out));
        end
        @(posedge clk); #1;
        advance = 1;
        @(posedge clk); #1;
        clear_inputs();
        readdata1_in = 64'd3; readdata2_in = 64'd4;
        push(64'd7);
        #3;
        chk({tag, " idle_alu"}, result_out);
        push(64'd0);
        chk({tag, " idle_stall"}, 64'(ex_stall_out));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset: stall and branch suppressed even with active requests
        reset = 1;
        clear_inputs();
        muldiv_in = 1; branch_in = 1; aluop_in = 2'b00;
        readdata1_in = 64'd9; readdata2_in = 64'd9;
        pc_in = 64'h1000; imm_data_in = 64'hFFFF_FFFF_FFFF_FFF8;
        #4;
        push(64'd0); chk("reset_stall", 64'(ex_stall_out));
        push(64'd0); chk("reset_taken", 64'(branch_taken_out));
        push(64'h1000 - 64'd8); chk("reset_target", branch_target_out);
        push(64'd9); chk("reset_store", store_data_out);
`ifdef EX_PERF_CNT_EN
        push(64'd0); chk("reset_perf", 64'(stall_cycles_out));
`endif
        @(posedge clk); #1;
        clear_inputs();
        reset = 0;

        // ALU
        alu_op("sub", 2'b10, 4'b1000, 0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd8);
        alu_op("sra", 2'b10, 4'b1101, 0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
        alu_op("srl", 2'b10, 4'b0101, 0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000);
        alu_op("srai", 2'b10, 4'b1101, 1, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
        alu_op("addi_f7", 2'b10, 4'b1000, 1, 64'd5, 64'd3, 64'd8);
        alu_op("sll_mask", 2'b10, 4'b0001, 0, 64'd1, 64'd68, 64'd16);
        alu_op("slt", 2'b10, 4'b0010, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        alu_op("sltu", 2'b10, 4'b0011, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        alu_op("xor", 2'b10, 4'b0100, 0, 64'hF0, 64'h3C, 64'hCC);
        alu_op("or", 2'b10, 4'b0110, 0, 64'hF0, 64'h3C, 64'hFC);
        alu_op("and", 2'b10, 4'b0111, 0, 64'hF0, 64'h3C, 64'h30);
        alu_op("aluop11", 2'b11, 4'b0000, 0, 64'd5, 64'd6, 64'd0);

        // Forwarding
        @(posedge clk); #1;
        clear_inputs();
        fwd_a_sel = 2'b10; exmem_result_in = 64'h10; alusrc_in = 1; imm_data_in = 64'd4;
        readdata1_in = 64'h100;
        push(64'h14); #3; chk("fwd_exmem", result_out);
        @(posedge clk); #1;
        fwd_a_sel = 2'b11;
        push(64'h104); #3; chk("fwd_sel11", result_out);
        @(posedge clk); #1;
        fwd_a_sel = 2'b01; wb_data_in = 64'h20;
        push(64'h24); #3; chk("fwd_wb", result_out);
        @(posedge clk); #1;
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b01; alusrc_in = 0; readdata2_in = 64'h7;
        push(64'h20); #3; chk("fwd_store", store_data_out);
        push(64'h120); chk("fwd_b_result", result_out);

        // Branch
        @(posedge clk); #1;
        clear_inputs();
        aluop_in = 2'b01; branch_in = 1; funct4_in = 4'b0100;
        readdata1_in = 64'hFFFF_FFFF_FFFF_FFFF; readdata2_in = 64'd1;
        pc_in = 64'h1000; imm_data_in = 64'hFFFF_FFFF_FFFF_FFF8;
        push(64'd1); #3; chk("blt_taken", 64'(branch_taken_out));
        push(64'hFFFF_FFFF_FFFF_FFFE); chk("branch_result", result_out);
        push(64'hFF8); chk("branch_target", branch_target_out);
        @(posedge clk); #1;
        funct4_in = 4'b0110;
        push(64'd0); #3; chk("bltu_not", 64'(branch_taken_out));
        @(posedge clk); #1;
        funct4_in = 4'b0111;
        push(64'd1); #3; chk("bgeu_taken", 64'(branch_taken_out));
        @(posedge clk); #1;
        funct4_in = 4'b0010;
        push(64'd0); #3; chk("b010_never", 64'(branch_taken_out));
        @(posedge clk); #1;
        funct4_in = 4'b0100; flush = 1;
        push(64'd0); #3; chk("blt_flushed", 64'(branch_taken_out));

        // Mul/div
        run_md("mul", 3'b000, 64'd7, 64'd6, 64'd42, 3);
`ifdef EX_PERF_CNT_EN
        push(64'd65); chk("perf_after_mul", 64'(stall_cycles_out));
`endif
        run_md("mulhu", 3'b011, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 0);
        run_md("divu_zero", 3'b101, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_md("rem_zero", 3'b110, 64'd9, 64'd0, 64'd9, 0);
        run_md("div_ovf", 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 0);
        run_md("rem_neg", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_md("div_neg", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_md("remu", 3'b111, 64'd10, 64'd3, 64'd1, 0);
        run_md("op001", 3'b001, 64'd10, 64'd3, 64'd0, 0);

        // Flush on BUSY cycle 10, then flush held with muldiv_in in IDLE
        @(posedge clk); #1;
        clear_inputs();
        muldiv_in = 1; aluop_in = 2'b10; readdata1_in = 64'd3; readdata2_in = 64'd5;
        repeat (10) @(posedge clk);
        #1;
        flush = 1;
        push(64'd1); #3; chk("flush_cycle_stall", 64'(ex_stall_out));
        @(posedge clk); #4;
        push(64'd0); chk("after_flush_stall", 64'(ex_stall_out));
        push(64'd8); chk("after_flush_result", result_out);
        @(posedge clk); #1;
        flush = 0; muldiv_in = 0;
        push(64'd0); #3; chk("no_start_stall", 64'(ex_stall_out));

        // Reset asserted mid-BUSY
        @(posedge clk); #1;
        clear_inputs();
        muldiv_in = 1; aluop_in = 2'b10; readdata1_in = 64'd9; readdata2_in = 64'd9;
        repeat (5) @(posedge clk);
        #1;
        reset = 1; aluop_in = 2'b00; branch_in = 1;
        push(64'd0); #3; chk("midreset_stall", 64'(ex_stall_out));
        push(64'd0); chk("midreset_taken", 64'(branch_taken_out));
        push(64'd18); chk("midreset_result", result_out);
        @(posedge clk); #1;
        reset = 0; muldiv_in = 0; branch_in = 0;
        push(64'd0); #3; chk("postreset_stall", 64'(ex_stall_out));
        push(64'd18); chk("postreset_result", result_out);
`ifdef EX_PERF_CNT_EN
        push(64'd0); chk("postreset_perf", 64'(stall_cycles_out));
`endif

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL leftover_queue: observed %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
